// File: rtl/bytecode_fetch_unit_pkg.sv
// Shared constants for the JVM bytecode fetch path.
// Fetch FSM encodings and default geometry.
package bytecode_fetch_unit_pkg;

   localparam int PC_W_DEF  = 16;
   localparam int DEPTH_DEF = 4;

   localparam logic [1:0] F_IDLE = 2'd0;
   localparam logic [1:0] F_REQ  = 2'd1;
   localparam logic [1:0] F_DROP = 2'd2;

endpackage

// File: rtl/bytecode_fetch_unit_if.sv
// Instruction memory read port: req/adr held until ack.
// master = fetch unit, slave = memory.
interface bytecode_fetch_unit_if #(
   parameter int PC_W = bytecode_fetch_unit_pkg::PC_W_DEF
);

   logic            req;
   logic [PC_W-1:0] adr;
   logic            ack;
   logic [7:0]      rdata;

   modport master (
      output req,
      output adr,
      input  ack,
      input  rdata
   );

   modport slave (
      input  req,
      input  adr,
      output ack,
      output rdata
   );

endinterface

// File: rtl/bytecode_fetch_unit_fifo.sv
// Prefetch byte FIFO with flush; head reads 0 when empty.
// Pointers wrap naturally; count is one bit wider.
module bytecode_fifo
   import bytecode_fetch_unit_pkg::*;
#(
   parameter  int DEPTH = DEPTH_DEF,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [7:0]    wdata,
   input  logic          pop,
   input  logic          flush,
   output logic [CW-1:0] count,
   output logic [7:0]    head,
   output logic          empty
);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign do_push = push && !flush;
   assign do_pop  = pop && !flush && !empty;
   assign head    = empty ? 8'h00 : mem[rd_ptr];

   // Pointer and occupancy tracking; flush empties in one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Byte storage, written at the tail.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= wdata;
   end

   // The fetch FSM stops requesting before the buffer fills.
   a_no_overflow : assert property (
      @(posedge clk) disable iff (!rst_n)
      !(do_push && count == CW'(DEPTH))
   );

endmodule

// File: rtl/bytecode_fetch_unit.sv
// Bytecode fetch: PC tracking, memory req/ack FSM and
// prefetch buffer feeding the JVM decoder one byte per advance.
module bytecode_fetch_unit
   import bytecode_fetch_unit_pkg::*;
#(
   parameter int              PC_W     = PC_W_DEF,
   parameter int              DEPTH    = DEPTH_DEF,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 advance,
   input  logic                 redirect,
   input  logic [PC_W-1:0]      redirect_pc,
   output logic [7:0]           iram_data,
   output logic                 waiting,
   output logic [PC_W-1:0]      head_pc,
   bytecode_fetch_unit_if.master mem
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [1:0]      state;
   logic [1:0]      state_nx;
   logic [PC_W-1:0] fetch_pc;
   logic [PC_W-1:0] fetch_nx;
   logic [PC_W-1:0] adr_q;
   logic [PC_W-1:0] adr_nx;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_nx;
   logic            push;
   logic            pop;
   logic            empty;

   // Data from a request that was redirected away is never pushed.
   assign push     = (state == F_REQ) && mem.ack && !redirect;
   assign pop      = advance && !redirect && !empty;
   assign count_nx = count + CW'(push) - CW'(pop);

   assign mem.req  = (state != F_IDLE);
   assign mem.adr  = adr_q;
   assign waiting  = empty;

   bytecode_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (reset),
      .push  (push),
      .wdata (mem.rdata),
      .pop   (pop),
      .flush (redirect),
      .count (count),
      .head  (iram_data),
      .empty (empty)
   );

   // Next fetch PC, request address and FSM state.
   always_comb begin
      state_nx = state;
      adr_nx   = adr_q;
      fetch_nx = fetch_pc;
      if (redirect)
         fetch_nx = redirect_pc;
      else if (push)
         fetch_nx = fetch_pc + PC_W'(1);
      case (state)
         F_IDLE: begin
            if (redirect || count < CW'(DEPTH)) begin
               state_nx = F_REQ;
               adr_nx   = fetch_nx;
            end
         end
         F_REQ: begin
            if (mem.ack) begin
               if (redirect || count_nx < CW'(DEPTH))
                  adr_nx = fetch_nx;
               else
                  state_nx = F_IDLE;
            end else if (redirect) begin
               state_nx = F_DROP;
            end
         end
         F_DROP: begin
            if (mem.ack) begin
               state_nx = F_REQ;
               adr_nx   = fetch_nx;
            end
         end
         default: state_nx = F_IDLE;
      endcase
   end

   // FSM, fetch PC and held request address.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= F_IDLE;
         fetch_pc <= RESET_PC;
         adr_q    <= RESET_PC;
      end else begin
         state    <= state_nx;
         fetch_pc <= fetch_nx;
         adr_q    <= adr_nx;
      end
   end

   // PC of the byte at the head of the buffer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         head_pc <= RESET_PC;
      else if (redirect)
         head_pc <= redirect_pc;
      else if (pop)
         head_pc <= head_pc + PC_W'(1);
   end

endmodule

// File: tb/tb_bytecode_fetch_unit.sv
// Scoreboard bench: expected byte stream per redirect/reset,
// variable-latency memory model and a decoupled output monitor.
module tb_bytecode_fetch_unit;
   import bytecode_fetch_unit_pkg::*;

   localparam int          PC_W   = 16;
   localparam logic [15:0] RST_PC = 16'h0000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        advance = 1'b0;
   logic        redirect = 1'b0;
   logic [15:0] redirect_pc = '0;
   logic [7:0]  iram_data;
   logic        waiting;
   logic [15:0] head_pc;

   bytecode_fetch_unit_if #(.PC_W(PC_W)) mif ();

   bytecode_fetch_unit #(
      .PC_W     (PC_W),
      .DEPTH    (4),
      .RESET_PC (RST_PC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .advance     (advance),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .iram_data   (iram_data),
      .waiting     (waiting),
      .head_pc     (head_pc),
      .mem         (mif)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] mem_byte(input logic [15:0] a);
      return a[7:0] ^ {a[12:8], a[15:13]};
   endfunction

   // Reference: after a (re)start at PC p the decoder sees
   // mem[p], mem[p+1], ... with head_pc p, p+1, ... (mod 2^16).
   logic [23:0] exp_q[$];

   task automatic fill(input logic [15:0] p);
      exp_q.delete();
      for (int i = 0; i < 128; i++) begin
         logic [15:0] q;
         q = p + 16'(i);
         exp_q.push_back({q, mem_byte(q)});
      end
   endtask

   // Memory model: latency from schedule, else default (-1 = random).
   int          lat_default = 0;
   int          lat_sched[$];
   bit          busy = 0;
   int          wcnt = 0;
   logic [15:0] held = '0;

   initial begin
      mif.ack = 1'b0;
      mif.rdata = '0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            mif.ack = 1'b0;
            busy = 0;
         end else begin
            if (mif.ack) begin
               mif.ack = 1'b0;
               busy = 0;
            end
            if (busy) begin
               check("req_held", mif.req, 1);
               check("adr_held", mif.adr, held);
               if (!mif.req) busy = 0;
            end else if (mif.req) begin
               busy = 1;
               held = mif.adr;
               if (lat_sched.size() > 0) wcnt = lat_sched.pop_front();
               else if (lat_default < 0) wcnt = $urandom_range(0, 3);
               else wcnt = lat_default;
            end
            if (busy) begin
               if (wcnt == 0) begin
                  mif.ack = 1'b1;
                  mif.rdata = mem_byte(mif.adr);
               end else begin
                  wcnt--;
               end
            end
         end
      end
   end

   // Advance driver: 0 off, 1 continuous, 2 random.
   int adv_mode = 0;
   initial forever begin
      @(posedge clk);
      #1;
      case (adv_mode)
         0: advance = 1'b0;
         1: advance = 1'b1;
         default: advance = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor: every consumed byte is checked against the queue.
   int          n_pops = 0;
   int          wait_cycles = 0;
   bit          redir_prev = 0;
   logic [15:0] redir_tgt = '0;

   initial forever begin
      @(negedge clk);
      if (!reset) begin
         redir_prev = 0;
      end else begin
         if (redir_prev) begin
            check("flush_waiting", waiting, 1);
            check("flush_head_pc", head_pc, redir_tgt);
         end
         if (waiting) begin
            wait_cycles++;
            check("empty_data", iram_data, 0);
         end
         if (advance && !redirect && !waiting) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_underrun got=byte exp=none t=%0t", $time);
            end else begin
               logic [23:0] e;
               e = exp_q.pop_front();
               check("head_pc", head_pc, e[23:8]);
               check("iram_data", iram_data, e[7:0]);
               n_pops++;
            end
         end
         redir_prev = redirect;
         redir_tgt = redirect_pc;
      end
   end

   task automatic wait_pops(input int n, input int budget);
      int target;
      int c;
      target = n_pops + n;
      c = 0;
      while (n_pops < target && c < budget) begin
         @(negedge clk);
         c++;
      end
      check("progress", n_pops >= target, 1);
   endtask

   task automatic reset_dut();
      @(posedge clk);
      #2;
      reset = 1'b0;
      lat_sched.delete();
      fill(RST_PC);
      #1;
      check("rst_waiting", waiting, 1);
      check("rst_iram_data", iram_data, 0);
      check("rst_head_pc", head_pc, RST_PC);
      check("rst_req", mif.req, 0);
      check("rst_adr", mif.adr, RST_PC);
      @(posedge clk);
      @(posedge clk);
      #3;
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic do_redirect(input logic [15:0] pc);
      @(posedge clk);
      #1;
      redirect = 1'b1;
      redirect_pc = pc;
      fill(pc);
      @(posedge clk);
      #1;
      redirect = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0;
      fill(RST_PC);

      // Zero-wait memory: 4 back-to-back fetches, then stop.
      lat_default = 0;
      adv_mode = 0;
      reset_dut();
      @(negedge clk);
      check("t1_req0", mif.req, 1);
      check("t1_adr0", mif.adr, 0);
      check("t1_wait0", waiting, 1);
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         check("t1_req", mif.req, 1);
         check("t1_adr", mif.adr, i);
         if (i == 1) check("t1_first_byte", waiting, 0);
      end
      @(negedge clk);
      check("t1_stop", mif.req, 0);
      @(negedge clk);
      check("t1_stop2", mif.req, 0);
      adv_mode = 1;
      wait_pops(4, 20);
      adv_mode = 0;

      // 3-cycle latency with continuous advance.
      lat_default = 3;
      reset_dut();
      adv_mode = 1;
      w0 = wait_cycles;
      wait_pops(20, 300);
      check("t2_waiting_between", (wait_cycles - w0) >= 40, 1);
      adv_mode = 0;

      // Redirect while a slow request is outstanding.
      lat_default = 0;
      reset_dut();
      lat_sched = '{0, 0, 10};
      repeat (4) @(posedge clk);
      do_redirect(16'h0100);
      @(negedge clk);
      check("t3_drop_req", mif.req, 1);
      check("t3_drop_adr", mif.adr, 16'h0002);
      adv_mode = 1;
      wait_pops(4, 60);
      adv_mode = 0;

      // Redirect coincident with ack and with advance.
      reset_dut();
      repeat (2) @(posedge clk);
      adv_mode = 1;
      do_redirect(16'h0200);
      @(negedge clk);
      check("t4_req", mif.req, 1);
      check("t4_adr", mif.adr, 16'h0200);
      wait_pops(6, 60);

      // PC wrap at the top of the address space.
      do_redirect(16'hfffe);
      wait_pops(3, 40);

      // Asynchronous reset mid-request with 3 bytes buffered.
      adv_mode = 0;
      repeat (8) @(posedge clk);
      lat_sched = '{0, 0, 0, 10};
      do_redirect(16'h0300);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("t6_pre_head", head_pc, 16'h0300);
      check("t6_pre_wait", waiting, 0);
      check("t6_pre_adr", mif.adr, 16'h0303);
      reset_dut();
      @(negedge clk);
      check("t6_restart_req", mif.req, 1);
      check("t6_restart_adr", mif.adr, RST_PC);
      adv_mode = 1;
      wait_pops(8, 60);

      // Random latency, advance and redirects.
      lat_default = -1;
      adv_mode = 2;
      for (int k = 0; k < 40; k++) begin
         repeat ($urandom_range(3, 40)) @(posedge clk);
         do_redirect(16'($urandom));
      end
      adv_mode = 1;
      wait_pops(10, 100);
      adv_mode = 0;
      repeat (2) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
